// File: rtl/ifid_hazard_controller_if.sv
// Pipeline-side bundle between the fetch/decode stages and the IF/ID hazard controller.
// All signals are per-cycle levels with no valid/ready handshake: hazard inputs are sampled every cycle and the control outputs apply in that same cycle.
interface ifid_hazard_controller_if;
  logic       icache_hit;
  logic       branch_taken;
  logic       idex_mem_read;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;

  modport master (
    output icache_hit, branch_taken, idex_mem_read, idex_rt, ifid_rs, ifid_rt,
    input  pc_write, ifid_write, ifid_flush, idex_bubble
  );

  modport slave (
    input  icache_hit, branch_taken, idex_mem_read, idex_rt, ifid_rs, ifid_rt,
    output pc_write, ifid_write, ifid_flush, idex_bubble
  );
endinterface

// File: rtl/ifid_hazard_controller.sv
// IF/ID advance/hold/flush sequencing with load-use, I-cache miss and taken-branch handling,
// plus saturating stall/flush counters and a sticky fetch-timeout flag.
module ifid_hazard_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MISS_LIMIT   = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  ifid_hazard_controller_if.slave bus,
  output logic                 fetch_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events,
  output logic [1:0]           state
);

  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [3:0]    FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [MW-1:0] MISS_MAX     = MW'(MISS_LIMIT);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MISS   = 2'd1,
    FLUSH  = 2'd2,
    UNUSED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    flush_cnt_q, flush_cnt_d;
  logic [MW-1:0] miss_cnt_q, miss_cnt_d;
  logic          lu;
  logic          branch_accept;
  logic          timeout_set;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble;

  assign lu = bus.idex_mem_read && (bus.idex_rt != 5'd0) &&
              ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));

  // State register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Next-state and sequencing counters
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    branch_accept = 1'b0;
    case (state_q)
      RUN, MISS: begin
        if (bus.branch_taken) begin
          branch_accept = 1'b1;
          flush_cnt_d   = FLUSH_RELOAD;
          miss_cnt_d    = '0;
          state_d       = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (lu) begin
          state_d = state_q;
        end else if (!bus.icache_hit) begin
          state_d = MISS;
          if (state_q == RUN)              miss_cnt_d = MW'(1);
          else if (miss_cnt_q != MISS_MAX) miss_cnt_d = miss_cnt_q + 1'b1;
        end else begin
          state_d    = RUN;
          miss_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (bus.branch_taken) begin
          branch_accept = 1'b1;
          flush_cnt_d   = FLUSH_RELOAD;
        end else if (flush_cnt_q <= 4'd1) begin
          state_d     = RUN;
          flush_cnt_d = 4'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = 4'd0;
        miss_cnt_d  = '0;
      end
    endcase
  end

  assign timeout_set = (miss_cnt_d == MISS_MAX) && (miss_cnt_d != '0);

  // Pipeline control outputs; reset forces a safe hold-and-flush pattern
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rstn) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN, MISS: begin
          if (bus.branch_taken) begin
            ifid_flush = 1'b1;
          end else if (lu || !bus.icache_hit) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        FLUSH: ifid_flush = 1'b1;
        default: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign state           = state_q;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      flush_cnt_q   <= 4'd0;
      miss_cnt_q    <= '0;
      fetch_timeout <= 1'b0;
      stall_cycles  <= '0;
      flush_events  <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      if (timeout_set) fetch_timeout <= 1'b1;
      if (!pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (branch_accept && (flush_events != '1)) flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_ifid_hazard_controller.sv
// Directed bench for ifid_hazard_controller (FLUSH_CYCLES=2, MISS_LIMIT=16, CNT_WIDTH=16).
module tb_ifid_hazard_controller;
  logic        clk;
  logic        rstn;
  logic        fetch_timeout;
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;
  logic [1:0]  state;
  int          checks;
  int          errors;

  ifid_hazard_controller_if bus ();

  ifid_hazard_controller #(
    .FLUSH_CYCLES(2),
    .MISS_LIMIT  (16),
    .CNT_WIDTH   (16)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .fetch_timeout(fetch_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .state        (state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control outputs as {pc_write, ifid_write, ifid_flush, idex_bubble}
  task automatic check_ctl(input string tag, input logic [3:0] exp);
    #1;
    check(tag, {28'd0, bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble}, {28'd0, exp});
  endtask

  task automatic idle();
    bus.icache_hit    = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.idex_mem_read = 1'b0;
    bus.idex_rt       = 5'd0;
    bus.ifid_rs       = 5'd0;
    bus.ifid_rt       = 5'd0;
  endtask

  localparam logic [3:0] ADV   = 4'b1100;
  localparam logic [3:0] HOLD  = 4'b0001;
  localparam logic [3:0] FLSH  = 4'b1110;
  localparam logic [3:0] RSTV  = 4'b0011;

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b1;
    idle();

    // Reset held, then released between edges
    #3;
    check_ctl("reset_outputs", RSTV);
    #8;
    rstn = 1'b0;
    check_ctl("post_reset_adv", ADV);
    check("post_reset_state", 32'(state), 32'd0);
    check("post_reset_stall", 32'(stall_cycles), 32'd0);
    check("post_reset_flush_ev", 32'(flush_events), 32'd0);
    check("post_reset_timeout", 32'(fetch_timeout), 32'd0);
    tick();

    // Load-use on rs
    bus.idex_mem_read = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
    check_ctl("lu_rs_hold", HOLD);
    tick();
    idle();
    check_ctl("lu_cleared_adv", ADV);
    check("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    check("lu_state", 32'(state), 32'd0);

    // idex_rt = 0 never stalls
    bus.idex_mem_read = 1'b1; bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0;
    check_ctl("lu_r0_no_stall", ADV);
    tick();
    check("lu_r0_stall_cnt", 32'(stall_cycles), 32'd1);

    // Load-use on rt; no load means no stall
    bus.idex_rt = 5'd7; bus.ifid_rs = 5'd3; bus.ifid_rt = 5'd7;
    check_ctl("lu_rt_hold", HOLD);
    bus.idex_mem_read = 1'b0;
    check_ctl("no_load_no_stall", ADV);
    bus.idex_mem_read = 1'b1;
    tick();
    check("lu_rt_stall_cnt", 32'(stall_cycles), 32'd2);
    idle();

    // Three-cycle miss
    bus.icache_hit = 1'b0;
    check_ctl("miss_hold", HOLD);
    tick();
    check("miss_state_1", 32'(state), 32'd1);
    tick();
    tick();
    check("miss_state_3", 32'(state), 32'd1);
    check("miss_stall_cnt", 32'(stall_cycles), 32'd5);
    bus.icache_hit = 1'b1;
    check_ctl("miss_hit_same_cycle", ADV);
    tick();
    check("miss_back_run", 32'(state), 32'd0);
    check("miss_no_timeout", 32'(fetch_timeout), 32'd0);
    check("miss_stall_final", 32'(stall_cycles), 32'd5);

    // 16-cycle miss sets the sticky timeout
    bus.icache_hit = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("timeout_not_yet", 32'(fetch_timeout), 32'd0);
    tick();
    check("timeout_set", 32'(fetch_timeout), 32'd1);
    check("timeout_stall_cnt", 32'(stall_cycles), 32'd21);
    bus.icache_hit = 1'b1;
    tick();
    check("timeout_sticky", 32'(fetch_timeout), 32'd1);
    check("timeout_run", 32'(state), 32'd0);

    // Single branch: two cycles of flush
    bus.branch_taken = 1'b1;
    check_ctl("br_detect", FLSH);
    tick();
    check("br_state_flush", 32'(state), 32'd2);
    check("br_events_1", 32'(flush_events), 32'd1);
    bus.branch_taken = 1'b0;
    check_ctl("br_second_flush", FLSH);
    tick();
    check("br_back_run", 32'(state), 32'd0);
    check_ctl("br_done_adv", ADV);

    // Branch again during FLUSH extends by one cycle
    bus.branch_taken = 1'b1;
    tick();
    check("br2_events", 32'(flush_events), 32'd2);
    check_ctl("br2_in_flush", FLSH);
    tick();
    check("br2_extend_state", 32'(state), 32'd2);
    check("br2_events_ext", 32'(flush_events), 32'd3);
    bus.branch_taken = 1'b0;
    check_ctl("br2_extra_flush", FLSH);
    tick();
    check("br2_run", 32'(state), 32'd0);
    check_ctl("br2_adv", ADV);

    // Branch beats load-use and miss; FLUSH ignores hazards
    bus.branch_taken = 1'b1; bus.icache_hit = 1'b0;
    bus.idex_mem_read = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
    check_ctl("prio_flush", FLSH);
    tick();
    check("prio_state", 32'(state), 32'd2);
    check("prio_events", 32'(flush_events), 32'd4);
    check("prio_stall", 32'(stall_cycles), 32'd21);
    bus.branch_taken = 1'b0;
    check_ctl("flush_ignores_hazards", FLSH);
    tick();
    idle();
    check("prio_run", 32'(state), 32'd0);

    // Branch during MISS aborts the miss
    bus.icache_hit = 1'b0;
    tick();
    check("abort_miss_state", 32'(state), 32'd1);
    bus.branch_taken = 1'b1;
    check_ctl("abort_flush", FLSH);
    tick();
    check("abort_state_flush", 32'(state), 32'd2);
    check("abort_events", 32'(flush_events), 32'd5);
    check("abort_stall", 32'(stall_cycles), 32'd22);
    idle();
    tick();
    check("abort_run", 32'(state), 32'd0);

    // Reset mid-MISS, no clock edge needed
    bus.icache_hit = 1'b0;
    tick();
    tick();
    check("mid_miss_state", 32'(state), 32'd1);
    check("mid_miss_stall", 32'(stall_cycles), 32'd24);
    rstn = 1'b1;
    check_ctl("mid_rst_outputs", RSTV);
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_stall", 32'(stall_cycles), 32'd0);
    check("mid_rst_events", 32'(flush_events), 32'd0);
    check("mid_rst_timeout", 32'(fetch_timeout), 32'd0);
    tick();
    rstn = 1'b0;

    // Miss counter restarts from zero
    for (int i = 0; i < 15; i++) tick();
    check("restart_no_timeout", 32'(fetch_timeout), 32'd0);
    tick();
    check("restart_timeout", 32'(fetch_timeout), 32'd1);
    check("restart_stall", 32'(stall_cycles), 32'd16);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifid_hazard_controller.md
# ifid_hazard_controller

Sequences the IF/ID pipeline register and PC update for the 5-stage MIPS core. Each cycle it decides whether the fetch stage advances, holds or is flushed, based on the I-cache hit, load-use hazards and taken branches. It drives the IF/ID write-enable (the register's `hit` input), an IF/ID flush, the PC write-enable and an ID/EX bubble. It also keeps saturating performance counters and a sticky fetch-timeout flag.

## Interface
- `FLUSH_CYCLES`, default 2: total cycles `ifid_flush` is held per taken branch, including the detect cycle; legal range 1..15.
- `MISS_LIMIT`, default 16: consecutive miss cycles that set `fetch_timeout`.
- `CNT_WIDTH`, default 16: width of the performance counters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset; asynchronous, active-high (1 = in reset).
- `icache_hit`  in  1  fetched instruction is valid this cycle.
- `branch_taken`  in  1  branch resolved taken this cycle.
- `idex_mem_read`  in  1  the instruction in EX is a load.
- `idex_rt`  in  5  destination register of the instruction in EX.
- `ifid_rs`, `ifid_rt`  in  5 each  source registers of the instruction in ID.
- `pc_write`  out  1  PC loads its next value.
- `ifid_write`  out  1  IF/ID loads; connects to the IFID register's `hit`.
- `ifid_flush`  out  1  IF/ID loads a NOP instead of the fetched word.
- `idex_bubble`  out  1  ID/EX loads a NOP.
- `fetch_timeout`  out  1  sticky miss-timeout flag.
- `stall_cycles`  out  CNT_WIDTH  count of cycles with `pc_write`=0.
- `flush_events`  out  CNT_WIDTH  count of accepted taken branches.
- `state`  out  2  current FSM state, for debug.

## Operation
- **States:**
  - RUN = 0
  - MISS = 1
  - FLUSH = 2
  - Encoding 3 is unused and recovers to RUN.
- **Hazard term:** `lu` = `idex_mem_read` & (`idex_rt` != 0) & (`idex_rt` == `ifid_rs` | `idex_rt` == `ifid_rt`).
- **Priority in RUN and MISS:** `branch_taken` > `lu` > miss.
- **RUN:**
  - `branch_taken`:
    - Outputs: `pc_write`=1, `ifid_write`=1, `ifid_flush`=1, `idex_bubble`=0.
    - Next state: FLUSH if `FLUSH_CYCLES`>1, else RUN.
    - Loads the flush counter with `FLUSH_CYCLES`-1.
  - `lu`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; stays in RUN. No state is needed because the bubble clears `lu` on the next cycle.
  - `!icache_hit`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; next state MISS; miss counter set to 1.
  - Otherwise: `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `idex_bubble`=0.
- **MISS:**
  - `branch_taken` aborts the miss exactly as in RUN.
  - `lu` holds the pipeline as in RUN and stays in MISS.
  - `!icache_hit` holds (`pc_write`=0, `ifid_write`=0, `idex_bubble`=1). The miss counter increments, saturating at `MISS_LIMIT`. `fetch_timeout` sets when the counter reaches `MISS_LIMIT`.
  - `icache_hit` gives normal advance outputs; next state RUN; miss counter cleared.
- **FLUSH:**
  - Outputs: `pc_write`=1, `ifid_write`=1, `ifid_flush`=1, `idex_bubble`=0.
  - `icache_hit` and `lu` are ignored, since ID holds a NOP.
  - The flush counter decrements; the state returns to RUN after the cycle in which the counter equals 1.
  - `branch_taken` in FLUSH reloads the counter with `FLUSH_CYCLES`-1 and increments `flush_events`.
- **Counters:**
  - `stall_cycles` increments in every non-reset cycle with `pc_write`=0.
  - `flush_events` increments on every accepted `branch_taken`.
  - Both saturate at all-ones and never wrap.
- `fetch_timeout` is cleared only by reset.

## Timing
- Control outputs are combinational from `state` and the current inputs: zero-cycle latency to the pipeline registers.
- `state`, all counters and `fetch_timeout` are registered.
- **Reset (`rstn`=1):** asynchronous and immediate.
  - `state`=RUN, counters=0, `fetch_timeout`=0.
  - While `rstn`=1, outputs are forced to `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `idex_bubble`=1.
  - Reset asserted mid-MISS or mid-FLUSH discards all progress.
- Normal operation resumes on the first rising edge after `rstn` falls.
- **Branch penalty:** exactly `FLUSH_CYCLES` cycles of `ifid_flush`=1.
- **Miss latency:** the pipeline advances in the same cycle `icache_hit` rises.

## Test plan
- **Reset:** hold `rstn`=1 for 10 ns, then release with `icache_hit`=1 and no hazards -> `state`=0, `pc_write`=`ifid_write`=1, `ifid_flush`=0, counters 0.
- **Load-use:** `idex_mem_read`=1, `idex_rt`=5, `ifid_rs`=5 for one cycle -> `pc_write`=0, `ifid_write`=0, `idex_bubble`=1 for 1 cycle; `stall_cycles`=1. Repeat with `idex_rt`=0 -> no stall.
- **Miss:** `icache_hit`=0 for 3 cycles, then 1 -> 3 stall cycles, state 1 then 0, `stall_cycles`=3, `fetch_timeout`=0. Then hold the miss for 16 cycles -> `fetch_timeout`=1, and it stays set after `icache_hit` returns.
- **Branch:** `branch_taken` pulse with `FLUSH_CYCLES`=2 -> `ifid_flush`=1 for exactly 2 cycles, `flush_events`=1. A second pulse on the FLUSH cycle -> flush extends by 1 more cycle, `flush_events`=2.
- **Priority:** `branch_taken`, `lu` and `!icache_hit` asserted together -> flush outputs, `pc_write`=1, next state FLUSH. A branch during MISS -> miss aborted, state 2.
- **Mid-operation reset:** assert `rstn` during MISS -> outputs forced to their reset values immediately (no clock edge), `state`=0; after release, the miss counter restarts from 0.
